// File: rtl/exception_ctrl.sv
// Exception/interrupt controller for the multicycle MIPS core: prioritises traps and
// maskable level IRQs, saves EPC/cause, redirects the PC to per-cause vectors, handles ERET.
module exception_ctrl #(
  parameter int              N_IRQ         = 4,
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] VECTOR_BASE   = 32'h0000_0100,
  parameter int unsigned     VECTOR_STRIDE = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_exc_opcode,
  input  logic             i_exc_overflow,
  input  logic             i_instr_boundary,
  input  logic [XLEN-1:0]  i_pc_cur,
  input  logic             i_eret,
  input  logic             i_mask_wr,
  input  logic [N_IRQ-1:0] i_mask_wdata,
  output logic             o_cpu_hold,
  output logic             o_pc_override_valid,
  output logic [XLEN-1:0]  o_pc_override,
  output logic [XLEN-1:0]  o_epc,
  output logic [7:0]       o_cause,
  output logic             o_in_handler,
  output logic [N_IRQ-1:0] o_mask,
  output logic             o_double_fault
);

  typedef enum logic [2:0] {
    S_RUN,
    S_SAVE,
    S_VECTOR,
    S_HANDLER,
    S_RETURN,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [XLEN-1:0]  r_epc;
  logic [7:0]       r_cause;
  logic [N_IRQ-1:0] r_mask;

  logic             w_sync_exc;
  logic [N_IRQ-1:0] w_irq_active;
  logic             w_irq_hit;
  logic [7:0]       w_irq_code;
  logic [7:0]       w_take_code;
  logic [XLEN-1:0]  w_vector;

  assign w_sync_exc   = i_exc_opcode | i_exc_overflow;
  assign w_irq_active = i_irq & r_mask;
  assign w_irq_hit    = |w_irq_active;

  // Scan from the top so the lowest active line wins.
  always_comb begin
    w_irq_code = 8'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_irq_active[i]) w_irq_code = 8'(i + 2);
    end
  end

  assign w_take_code = i_exc_opcode   ? 8'd0 :
                       i_exc_overflow ? 8'd1 : w_irq_code;

  assign w_vector = VECTOR_BASE + (XLEN'(r_cause) * XLEN'(VECTOR_STRIDE));

  always_comb begin
    w_state_next        = r_state;
    o_cpu_hold          = 1'b0;
    o_pc_override_valid = 1'b0;
    o_pc_override       = '0;
    o_in_handler        = 1'b0;
    o_double_fault      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_sync_exc || (i_instr_boundary && w_irq_hit)) w_state_next = S_SAVE;
      end
      S_SAVE: begin
        o_cpu_hold   = 1'b1;
        w_state_next = S_VECTOR;
      end
      S_VECTOR: begin
        o_cpu_hold          = 1'b1;
        o_pc_override_valid = 1'b1;
        o_pc_override       = w_vector;
        w_state_next        = S_HANDLER;
      end
      S_HANDLER: begin
        o_in_handler = 1'b1;
        if (w_sync_exc)  w_state_next = S_HALT;
        else if (i_eret) w_state_next = S_RETURN;
      end
      S_RETURN: begin
        o_cpu_hold          = 1'b1;
        o_pc_override_valid = 1'b1;
        o_pc_override       = r_epc;
        o_in_handler        = 1'b1;
        w_state_next        = w_sync_exc ? S_HALT : S_RUN;
      end
      S_HALT: begin
        o_cpu_hold     = 1'b1;
        o_double_fault = 1'b1;
      end
      default: w_state_next = S_RUN;
    endcase
  end

  // Cause and EPC are captured on the request edge so they are already valid during SAVE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_RUN;
      r_epc   <= '0;
      r_cause <= 8'd0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_RUN && w_state_next == S_SAVE) begin
        r_cause <= w_take_code;
        r_epc   <= w_sync_exc ? (i_pc_cur - XLEN'(4)) : i_pc_cur;
      end
      if (w_state_next == S_HALT && r_state != S_HALT) r_cause <= 8'hFF;
      if (i_mask_wr && r_state != S_HALT) r_mask <= i_mask_wdata;
    end
  end

  assign o_epc   = r_epc;
  assign o_cause = r_cause;
  assign o_mask  = r_mask;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed test-plan scenarios followed by random traffic, all checked every cycle
// against an event-level model of the controller.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq;
  logic        exc_op, exc_ov, ib, eret, mask_wr;
  logic [31:0] pc_cur;
  logic [3:0]  mask_wdata;
  logic        cpu_hold, ov_valid, in_handler, dfault;
  logic [31:0] pc_ovr, epc;
  logic [7:0]  cause;
  logic [3:0]  mask;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: request phase counter (0 none, 1 = cycle after request, 2 = redirect cycle)
  int          m_since;
  bit          m_handler, m_returning, m_halted;
  logic [31:0] m_epc;
  logic [7:0]  m_cause;
  logic [3:0]  m_mask;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_irq              (irq),
    .i_exc_opcode       (exc_op),
    .i_exc_overflow     (exc_ov),
    .i_instr_boundary   (ib),
    .i_pc_cur           (pc_cur),
    .i_eret             (eret),
    .i_mask_wr          (mask_wr),
    .i_mask_wdata       (mask_wdata),
    .o_cpu_hold         (cpu_hold),
    .o_pc_override_valid(ov_valid),
    .o_pc_override      (pc_ovr),
    .o_epc              (epc),
    .o_cause            (cause),
    .o_in_handler       (in_handler),
    .o_mask             (mask),
    .o_double_fault     (dfault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_since = 0; m_handler = 0; m_returning = 0; m_halted = 0;
    m_epc = 32'd0; m_cause = 8'd0; m_mask = 4'd0;
  endtask

  task automatic check_outputs();
    bit          e_hold, e_ov;
    logic [31:0] e_po;
    e_hold = m_halted || (m_since > 0) || m_returning;
    e_ov   = (m_since == 2) || m_returning;
    e_po   = (m_since == 2) ? 32'h100 + {24'd0, m_cause} * 32'd4 :
             m_returning    ? m_epc : 32'd0;
    check("hold",     {31'd0, cpu_hold},   {31'd0, e_hold});
    check("ovalid",   {31'd0, ov_valid},   {31'd0, e_ov});
    check("override", pc_ovr,              e_po);
    check("epc",      epc,                 m_epc);
    check("cause",    {24'd0, cause},      {24'd0, m_cause});
    check("inh",      {31'd0, in_handler}, {31'd0, (m_handler || m_returning)});
    check("mask",     {28'd0, mask},       {28'd0, m_mask});
    check("dfault",   {31'd0, dfault},     {31'd0, m_halted});
  endtask

  task automatic model_update(input bit r, op, ov, input logic [3:0] rq, input bit b,
                              input logic [31:0] pc, input bit er, mw, input logic [3:0] md);
    logic [3:0] act;
    act = rq & m_mask;
    if (r) begin
      model_reset();
      return;
    end
    if (m_halted) return;
    if (mw) m_mask = md;
    if (m_since == 1) begin
      m_since = 2;
    end else if (m_since == 2) begin
      m_since = 0; m_handler = 1;
    end else if (m_handler || m_returning) begin
      if (op || ov) begin
        m_halted = 1; m_cause = 8'hFF; m_handler = 0; m_returning = 0;
        $display("HALT cyc=%0d", cyc);
      end else if (m_returning) begin
        m_returning = 0;
      end else if (er) begin
        m_handler = 0; m_returning = 1;
      end
    end else if (op || ov) begin
      m_cause = op ? 8'd0 : 8'd1; m_epc = pc - 32'd4; m_since = 1;
      $display("EVT cyc=%0d cause=%0d epc=%08h", cyc, m_cause, m_epc);
    end else if (b && act != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (act[i]) begin
          m_cause = 8'(2 + i);
          break;
        end
      end
      m_epc = pc; m_since = 1;
      $display("EVT cyc=%0d cause=%0d epc=%08h", cyc, m_cause, m_epc);
    end
  endtask

  // Called just after a falling edge: check, drive, clock, update model.
  task automatic cycle(input bit r, op, ov, input logic [3:0] rq, input bit b,
                       input logic [31:0] pc, input bit er, mw, input logic [3:0] md);
    check_outputs();
    rst = r; exc_op = op; exc_ov = ov; irq = rq; ib = b;
    pc_cur = pc; eret = er; mask_wr = mw; mask_wdata = md;
    @(posedge clk);
    model_update(r, op, ov, rq, b, pc, er, mw, md);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] pc);
    cycle(0, 0, 0, 4'h0, 0, pc, 0, 0, 4'h0);
  endtask

  initial begin
    rst = 1; exc_op = 0; exc_ov = 0; irq = 0; ib = 0;
    pc_cur = 0; eret = 0; mask_wr = 0; mask_wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle(1, 0, 0, 4'h0, 0, 32'h0, 0, 0, 4'h0);

    // Opcode trap
    cycle(0, 1, 0, 4'h0, 0, 32'h24, 0, 0, 4'h0);
    check("tp_op_epc", epc, 32'h20);
    check("tp_op_cause", {24'd0, cause}, 32'd0);
    idle(32'h24);
    check("tp_op_ov", {31'd0, ov_valid}, 32'd1);
    check("tp_op_vec", pc_ovr, 32'h100);
    idle(32'h100);
    check("tp_op_inh", {31'd0, in_handler}, 32'd1);
    cycle(0, 0, 0, 4'h0, 0, 32'h104, 1, 0, 4'h0);
    idle(32'h20);

    // Masked IRQ, then mask write (old mask applies on the write cycle)
    repeat (3) cycle(0, 0, 0, 4'b0100, 1, 32'h30, 0, 0, 4'h0);
    check("tp_msk_none", {31'd0, cpu_hold}, 32'd0);
    cycle(0, 0, 0, 4'b0100, 1, 32'h3c, 0, 1, 4'b0110);
    check("tp_msk_old", {31'd0, cpu_hold}, 32'd0);
    cycle(0, 0, 0, 4'b0100, 1, 32'h40, 0, 0, 4'h0);
    check("tp_msk_cause", {24'd0, cause}, 32'd4);
    check("tp_msk_epc", epc, 32'h40);
    idle(32'h40);
    check("tp_msk_vec", pc_ovr, 32'h110);
    idle(32'h110);

    // ERET restores EPC; eret in RUN does nothing
    cycle(0, 0, 0, 4'h0, 0, 32'h114, 1, 0, 4'h0);
    check("tp_eret_ov", {31'd0, ov_valid}, 32'd1);
    check("tp_eret_pc", pc_ovr, 32'h40);
    idle(32'h40);
    check("tp_eret_inh", {31'd0, in_handler}, 32'd0);
    cycle(0, 0, 0, 4'h0, 0, 32'h44, 1, 0, 4'h0);
    check("tp_eret_run", {31'd0, ov_valid}, 32'd0);

    // Priority: overflow beats irq[0]/irq[1]; irq[0] taken after return
    cycle(0, 0, 0, 4'h0, 0, 32'h48, 0, 1, 4'hF);
    cycle(0, 0, 1, 4'b0011, 1, 32'h80, 0, 0, 4'h0);
    check("tp_pri_cause", {24'd0, cause}, 32'd1);
    idle(32'h80);
    check("tp_pri_vec", pc_ovr, 32'h104);
    idle(32'h104);
    cycle(0, 0, 0, 4'h0, 0, 32'h108, 1, 0, 4'h0);
    idle(32'h7c);
    cycle(0, 0, 0, 4'b0011, 1, 32'h90, 0, 0, 4'h0);
    check("tp_pri_cause2", {24'd0, cause}, 32'd2);
    idle(32'h90);
    check("tp_pri_vec2", pc_ovr, 32'h108);
    idle(32'h108);

    // Double fault with simultaneous eret, sticky for 20 cycles, then reset
    cycle(0, 0, 1, 4'h0, 0, 32'h10c, 1, 0, 4'h0);
    check("tp_df_cause", {24'd0, cause}, 32'hFF);
    for (int i = 0; i < 20; i++) begin
      cycle(0, i[0], i[1], 4'($urandom_range(0, 15)), 1, 32'h200, i[2], 1, 4'h5);
      check("tp_df_hold", {31'd0, cpu_hold}, 32'd1);
    end
    check("tp_df_flag", {31'd0, dfault}, 32'd1);
    cycle(1, 0, 0, 4'h0, 0, 32'h0, 0, 0, 4'h0);
    check("tp_rst_cause", {24'd0, cause}, 32'd0);
    check("tp_rst_df", {31'd0, dfault}, 32'd0);
    check("tp_rst_hold", {31'd0, cpu_hold}, 32'd0);

    // Reset during SAVE
    cycle(0, 1, 0, 4'h0, 0, 32'h60, 0, 0, 4'h0);
    cycle(1, 0, 0, 4'h0, 0, 32'h60, 0, 0, 4'h0);
    check("tp_rs_ov", {31'd0, ov_valid}, 32'd0);
    check("tp_rs_epc", epc, 32'd0);
    idle(32'h60);
    check("tp_rs_ov2", {31'd0, ov_valid}, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 79) == 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 39) == 0,
            4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0,
            $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0,
            4'($urandom_range(0, 15)));
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
